// File: rtl/smc_access_ctrl_lite.sv
// rtl/smc_access_ctrl_lite.sv - access sequencer for the lite static memory controller
module smc_access_ctrl_lite (
    input  logic       sys_clk,
    input  logic       n_sys_reset,
    input  logic       valid_access,
    input  logic [1:0] v_xfer_size,
    input  logic [1:0] v_bus_size,
    input  logic [1:0] cfg_csle,
    input  logic [3:0] cfg_wait,
    input  logic [1:0] cfg_float,
    output logic [4:0] smc_nextstate,
    output logic       smc_done,
    output logic       mac_done,
    output logic [1:0] r_num_access,
    output logic       smc_busy
);

    localparam logic [1:0] XSIZ_16 = 2'b01;
    localparam logic [1:0] XSIZ_32 = 2'b10;
    localparam logic [1:0] BSIZ_8  = 2'b00;
    localparam logic [1:0] BSIZ_16 = 2'b01;

    typedef enum logic [4:0] {
        SMC_IDLE  = 5'b00001,
        SMC_LE    = 5'b00010,
        SMC_RW    = 5'b00100,
        SMC_FLOAT = 5'b01000
    } smc_state_t;

    smc_state_t r_state;
    smc_state_t nxt_state;

    // Phase counter and configuration captured at the start of each access
    logic [3:0] wcnt;
    logic [1:0] r_csle;
    logic [3:0] r_wait;
    logic [1:0] r_float;

    logic [1:0] num_minus1;
    logic       wcnt_zero;
    logic       last_sub;
    logic [3:0] le_load_live;
    logic [3:0] le_load_lat;
    logic [3:0] float_load;

    assign wcnt_zero    = (wcnt == 4'd0);
    assign last_sub     = (r_num_access == 2'd0);
    // Phase lengths are loaded minus one; the zero case of csle/float skips the phase
    assign le_load_live = {2'b00, cfg_csle} - 4'd1;
    assign le_load_lat  = {2'b00, r_csle} - 4'd1;
    assign float_load   = {2'b00, r_float} - 4'd1;

    // Sub-accesses minus one: wide transfers on narrow buses split into 4 or 2 pieces
    always_comb begin
        num_minus1 = 2'd0;
        if (v_xfer_size == XSIZ_32 && v_bus_size == BSIZ_8) begin
            num_minus1 = 2'd3;
        end else if ((v_xfer_size == XSIZ_32 && v_bus_size == BSIZ_16) ||
                     (v_xfer_size == XSIZ_16 && v_bus_size == BSIZ_8)) begin
            num_minus1 = 2'd1;
        end
    end

    // Strobe completion flags; independent of valid_access by construction
    always_comb begin
        smc_done = (r_state == SMC_RW) && wcnt_zero;
        mac_done = smc_done && last_sub;
    end

    // Next-state decode; IDLE looks at the live csle because capture happens on the same edge
    always_comb begin
        nxt_state = SMC_IDLE;
        case (r_state)
            SMC_IDLE: begin
                if (valid_access) begin
                    nxt_state = (cfg_csle != 2'd0) ? SMC_LE : SMC_RW;
                end else begin
                    nxt_state = SMC_IDLE;
                end
            end
            SMC_LE: begin
                nxt_state = wcnt_zero ? SMC_RW : SMC_LE;
            end
            SMC_RW: begin
                if (!wcnt_zero) begin
                    nxt_state = SMC_RW;
                end else if (!last_sub) begin
                    nxt_state = (r_csle != 2'd0) ? SMC_LE : SMC_RW;
                end else begin
                    nxt_state = (r_float != 2'd0) ? SMC_FLOAT : SMC_IDLE;
                end
            end
            SMC_FLOAT: begin
                nxt_state = wcnt_zero ? SMC_IDLE : SMC_FLOAT;
            end
            default: begin
                nxt_state = SMC_IDLE;
            end
        endcase
    end

    assign smc_nextstate = nxt_state;

    // State, phase counter, sub-access count and captured configuration
    always_ff @(posedge sys_clk or negedge n_sys_reset) begin
        if (!n_sys_reset) begin
            r_state      <= SMC_IDLE;
            wcnt         <= 4'd0;
            r_num_access <= 2'd0;
            r_csle       <= 2'd0;
            r_wait       <= 4'd0;
            r_float      <= 2'd0;
            smc_busy     <= 1'b0;
        end else begin
            r_state  <= nxt_state;
            smc_busy <= (nxt_state != SMC_IDLE);
            case (r_state)
                SMC_IDLE: begin
                    if (valid_access) begin
                        r_csle       <= cfg_csle;
                        r_wait       <= cfg_wait;
                        r_float      <= cfg_float;
                        r_num_access <= num_minus1;
                        wcnt         <= (cfg_csle != 2'd0) ? le_load_live : cfg_wait;
                    end
                end
                SMC_LE: begin
                    wcnt <= wcnt_zero ? r_wait : (wcnt - 4'd1);
                end
                SMC_RW: begin
                    if (!wcnt_zero) begin
                        wcnt <= wcnt - 4'd1;
                    end else if (!last_sub) begin
                        // The address block samples the pre-decrement count during this cycle
                        r_num_access <= r_num_access - 2'd1;
                        wcnt         <= (r_csle != 2'd0) ? le_load_lat : r_wait;
                    end else begin
                        wcnt <= (r_float != 2'd0) ? float_load : 4'd0;
                    end
                end
                SMC_FLOAT: begin
                    wcnt <= wcnt_zero ? 4'd0 : (wcnt - 4'd1);
                end
                default: begin
                    wcnt         <= 4'd0;
                    r_num_access <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smc_access_ctrl_lite.sv
// tb/tb_smc_access_ctrl_lite.sv - directed bench for smc_access_ctrl_lite
module tb_smc_access_ctrl_lite;

    localparam logic [4:0] ST_IDLE  = 5'b00001;
    localparam logic [4:0] ST_LE    = 5'b00010;
    localparam logic [4:0] ST_RW    = 5'b00100;
    localparam logic [4:0] ST_FLOAT = 5'b01000;

    logic       sys_clk;
    logic       n_sys_reset;
    logic       valid_access;
    logic [1:0] v_xfer_size;
    logic [1:0] v_bus_size;
    logic [1:0] cfg_csle;
    logic [3:0] cfg_wait;
    logic [1:0] cfg_float;
    logic [4:0] smc_nextstate;
    logic       smc_done;
    logic       mac_done;
    logic [1:0] r_num_access;
    logic       smc_busy;

    int total;
    int bad;

    typedef struct {
        logic [1:0] xs;
        logic [1:0] bs;
        logic [1:0] cs;
        logic [3:0] ws;
        logic [1:0] fs;
        int         exp_cyc;
        int         exp_done;
        int         exp_num;
    } vec_t;

    vec_t vecs[11];

    smc_access_ctrl_lite dut (
        .sys_clk       (sys_clk),
        .n_sys_reset   (n_sys_reset),
        .valid_access  (valid_access),
        .v_xfer_size   (v_xfer_size),
        .v_bus_size    (v_bus_size),
        .cfg_csle      (cfg_csle),
        .cfg_wait      (cfg_wait),
        .cfg_float     (cfg_float),
        .smc_nextstate (smc_nextstate),
        .smc_done      (smc_done),
        .mac_done      (mac_done),
        .r_num_access  (r_num_access),
        .smc_busy      (smc_busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] xs, input logic [1:0] bs, input logic [1:0] cs,
                           input logic [3:0] ws, input logic [1:0] fs);
        v_xfer_size = xs;
        v_bus_size  = bs;
        cfg_csle    = cs;
        cfg_wait    = ws;
        cfg_float   = fs;
    endtask

    // Launch one access and count busy cycles, smc_done and mac_done pulses
    task automatic run_access(input logic [1:0] xs, input logic [1:0] bs, input logic [1:0] cs,
                              input logic [3:0] ws, input logic [1:0] fs,
                              output int cyc, output int nd, output int nm, output int num0);
        step();
        set_cfg(xs, bs, cs, ws, fs);
        valid_access = 1'b1;
        step();
        valid_access = 1'b0;
        num0 = int'(r_num_access);
        cyc = 0;
        nd  = 0;
        nm  = 0;
        while (smc_busy && cyc < 200) begin
            cyc++;
            if (smc_done) nd++;
            if (mac_done) nm++;
            step();
        end
    endtask

    int cyc, nd, nm, num0;
    logic [4:0] exp_ns[8];
    logic       exp_d[8];
    logic       exp_m[8];

    initial begin
        total = 0;
        bad   = 0;
        n_sys_reset  = 1'b0;
        valid_access = 1'b0;
        set_cfg(2'b00, 2'b00, 2'b00, 4'd0, 2'b00);

        vecs[0]  = '{2'b10, 2'b10, 2'd0, 4'd0,  2'd0, 1,  1, 0};
        vecs[1]  = '{2'b10, 2'b00, 2'd0, 4'd1,  2'd0, 8,  4, 3};
        vecs[2]  = '{2'b01, 2'b00, 2'd2, 4'd0,  2'd1, 7,  2, 1};
        vecs[3]  = '{2'b10, 2'b01, 2'd1, 4'd2,  2'd3, 11, 2, 1};
        vecs[4]  = '{2'b11, 2'b00, 2'd0, 4'd0,  2'd0, 1,  1, 0};
        vecs[5]  = '{2'b00, 2'b10, 2'd3, 4'd0,  2'd0, 4,  1, 0};
        vecs[6]  = '{2'b01, 2'b01, 2'd0, 4'd0,  2'd2, 3,  1, 0};
        vecs[7]  = '{2'b10, 2'b00, 2'd3, 4'd15, 2'd3, 79, 4, 3};
        vecs[8]  = '{2'b01, 2'b10, 2'd0, 4'd15, 2'd0, 16, 1, 0};
        vecs[9]  = '{2'b00, 2'b00, 2'd1, 4'd0,  2'd1, 3,  1, 0};
        vecs[10] = '{2'b10, 2'b11, 2'd2, 4'd3,  2'd0, 6,  1, 0};

        // Reset state
        step();
        step();
        chk("rst_nextstate", smc_nextstate, ST_IDLE);
        chk("rst_done", smc_done, 0);
        chk("rst_mac", mac_done, 0);
        chk("rst_num", r_num_access, 0);
        chk("rst_busy", smc_busy, 0);
        n_sys_reset = 1'b1;
        step();
        chk("post_rst_nextstate", smc_nextstate, ST_IDLE);

        // Minimum single access
        set_cfg(2'b10, 2'b10, 2'd0, 4'd0, 2'd0);
        valid_access = 1'b1;
        #1;
        chk("min_c0_nextstate", smc_nextstate, ST_RW);
        step();
        valid_access = 1'b0;
        chk("min_c1_done", smc_done, 1);
        chk("min_c1_mac", mac_done, 1);
        chk("min_c1_busy", smc_busy, 1);
        chk("min_c1_num", r_num_access, 0);
        chk("min_c1_nextstate", smc_nextstate, ST_IDLE);
        step();
        chk("min_c2_busy", smc_busy, 0);
        chk("min_c2_done", smc_done, 0);

        // 32-bit on 8-bit bus, wait = 1
        set_cfg(2'b10, 2'b00, 2'd0, 4'd1, 2'd0);
        valid_access = 1'b1;
        #1;
        chk("w1_c0_nextstate", smc_nextstate, ST_RW);
        for (int c = 1; c <= 8; c++) begin
            step();
            valid_access = 1'b0;
            chk($sformatf("w1_c%0d_busy", c), smc_busy, 1);
            chk($sformatf("w1_c%0d_done", c), smc_done, (c % 2 == 0) ? 1 : 0);
            chk($sformatf("w1_c%0d_mac", c), mac_done, (c == 8) ? 1 : 0);
            chk($sformatf("w1_c%0d_num", c), r_num_access, 3 - (c - 1) / 2);
            chk($sformatf("w1_c%0d_nextstate", c), smc_nextstate, (c == 8) ? ST_IDLE : ST_RW);
        end
        step();
        chk("w1_c9_busy", smc_busy, 0);

        // 16-bit on 8-bit bus, csle = 2, float = 1
        exp_ns[1] = ST_LE;  exp_d[1] = 1'b0; exp_m[1] = 1'b0;
        exp_ns[2] = ST_RW;  exp_d[2] = 1'b0; exp_m[2] = 1'b0;
        exp_ns[3] = ST_LE;  exp_d[3] = 1'b1; exp_m[3] = 1'b0;
        exp_ns[4] = ST_LE;  exp_d[4] = 1'b0; exp_m[4] = 1'b0;
        exp_ns[5] = ST_RW;  exp_d[5] = 1'b0; exp_m[5] = 1'b0;
        exp_ns[6] = ST_FLOAT; exp_d[6] = 1'b1; exp_m[6] = 1'b1;
        exp_ns[7] = ST_IDLE;  exp_d[7] = 1'b0; exp_m[7] = 1'b0;
        set_cfg(2'b01, 2'b00, 2'd2, 4'd0, 2'd1);
        valid_access = 1'b1;
        #1;
        chk("le_c0_nextstate", smc_nextstate, ST_LE);
        for (int c = 1; c <= 7; c++) begin
            step();
            valid_access = 1'b0;
            chk($sformatf("le_c%0d_nextstate", c), smc_nextstate, exp_ns[c]);
            chk($sformatf("le_c%0d_done", c), smc_done, exp_d[c]);
            chk($sformatf("le_c%0d_mac", c), mac_done, exp_m[c]);
            chk($sformatf("le_c%0d_busy", c), smc_busy, 1);
        end
        step();
        chk("le_c8_busy", smc_busy, 0);

        // valid_access pulsed during cycle 2 of a 4-cycle access
        set_cfg(2'b10, 2'b10, 2'd1, 4'd2, 2'd0);
        valid_access = 1'b1;
        step();
        valid_access = 1'b0;
        cyc = 0;
        nd  = 0;
        while (smc_busy && cyc < 50) begin
            cyc++;
            if (smc_done) nd++;
            if (cyc == 2) begin
                set_cfg(2'b10, 2'b00, 2'd0, 4'd0, 2'd0);
                valid_access = 1'b1;
                #1;
                chk("busy_req_nextstate", smc_nextstate, ST_RW);
            end else begin
                valid_access = 1'b0;
            end
            if (cyc == 3) chk("busy_req_num", r_num_access, 0);
            step();
        end
        valid_access = 1'b0;
        chk("busy_req_cycles", cyc, 4);
        chk("busy_req_dones", nd, 1);
        step();
        chk("busy_req_no_restart", smc_busy, 0);

        // Reset in the middle of a 4-sub-access transfer
        set_cfg(2'b10, 2'b00, 2'd0, 4'd1, 2'd0);
        valid_access = 1'b1;
        step();
        valid_access = 1'b0;
        step();
        step();
        chk("mid_rst_pre_num", r_num_access, 2);
        n_sys_reset = 1'b0;
        #1;
        chk("mid_rst_busy", smc_busy, 0);
        chk("mid_rst_num", r_num_access, 0);
        chk("mid_rst_done", smc_done, 0);
        chk("mid_rst_mac", mac_done, 0);
        chk("mid_rst_nextstate", smc_nextstate, ST_IDLE);
        step();
        chk("mid_rst_hold_done", smc_done, 0);
        n_sys_reset = 1'b1;
        run_access(2'b10, 2'b00, 2'd0, 4'd0, 2'd0, cyc, nd, nm, num0);
        chk("after_rst_cycles", cyc, 4);
        chk("after_rst_dones", nd, 4);
        chk("after_rst_num0", num0, 3);

        // wait = 15: first smc_done on the 16th RW cycle
        set_cfg(2'b00, 2'b00, 2'd0, 4'd15, 2'd0);
        valid_access = 1'b1;
        step();
        valid_access = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("w15_c%0d_done", c), smc_done, (c == 16) ? 1 : 0);
            step();
        end
        chk("w15_end_busy", smc_busy, 0);

        // Table-driven access lengths and pulse counts
        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i].xs, vecs[i].bs, vecs[i].cs, vecs[i].ws, vecs[i].fs,
                       cyc, nd, nm, num0);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("vec%0d_dones", i), nd, vecs[i].exp_done);
            chk($sformatf("vec%0d_macs", i), nm, 1);
            chk($sformatf("vec%0d_num0", i), num0, vecs[i].exp_num);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
